inv_scheduler: RTL
==================

INV_SCHEDULER -- requirements
Module: inv_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one GF(2) matrix inverter.
REQ-002 Parameter RANK_MAX, default 936, SHALL set the largest legal job rank; RANK_W = $clog2(RANK_MAX) SHALL be derived.
REQ-003 Parameter TIMEOUT_CYC, default 4096, SHALL set the cycles allowed from inv_start to inv_done.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 req  input  NUM_REQ  SHALL carry per-requester job-request levels.
REQ-007 req_rank  input  NUM_REQ*RANK_W  SHALL carry the rank for requester r in bits [r*RANK_W +: RANK_W].
REQ-008 ack  output  NUM_REQ  SHALL be a one-hot, one-cycle completion pulse.
REQ-009 resp_success  output  1  SHALL be valid only while any ack bit is high.
REQ-010 resp_timeout  output  1  SHALL be valid only while any ack bit is high.
REQ-011 inv_start  output  1  SHALL be the one-cycle start pulse to the inverter.
REQ-012 inv_rank  output  RANK_W  SHALL be the rank to the inverter, held from ISSUE through WAIT.
REQ-013 inv_sel  output  $clog2(NUM_REQ)  SHALL be the granted requester index, used to steer the matrix mux; held from ISSUE through RESP.
REQ-014 inv_abort  output  1  SHALL be the one-cycle pulse to reset the inverter on timeout.
REQ-015 inv_done  input  1  SHALL indicate inverter completion.
REQ-016 inv_success  input  1  SHALL be the inverter result flag, sampled with inv_done.
REQ-017 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, all encoded in registers.
REQ-019 In IDLE with any req bit high, the block SHALL grant by round-robin: the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - It SHALL latch inv_sel and rank, then enter ISSUE.
REQ-020 rr_ptr SHALL reset to 0 and, on each ack, load (granted index + 1) mod NUM_REQ.
REQ-021 In ISSUE, inv_start SHALL be 1 for exactly one cycle, the timeout counter SHALL clear, and the next state SHALL be WAIT.
REQ-022 Grant-to-start latency SHALL be 1 cycle: req sampled in IDLE at edge t gives inv_start high during cycle t+1.
REQ-023 In WAIT, the counter SHALL increment each cycle; inv_done=1 SHALL capture inv_success and enter RESP.
REQ-024 If the counter reaches TIMEOUT_CYC-1 without inv_done, the block SHALL pulse inv_abort for one cycle, record timeout=1 and success=0, and enter RESP.
REQ-025 If inv_done and timeout coincide in the same cycle, inv_done SHALL win: no abort, and the result is taken.
REQ-026 In RESP, ack[inv_sel], resp_success and resp_timeout SHALL be driven for one cycle, then the FSM SHALL return to IDLE.
  - The earliest next grant SHALL be the following cycle.
REQ-027 A latched rank of 0 SHALL skip the inverter: ISSUE goes directly to RESP with success=1, timeout=0 and no inv_start.
REQ-028 A latched rank above RANK_MAX SHALL skip the inverter: ISSUE goes to RESP with success=0, timeout=0 and no inv_start.
REQ-029 Requesters SHALL hold req high until their ack.
  - req changes by the granted requester after grant SHALL be ignored.
  - A req dropped before grant SHALL be treated as withdrawn.
REQ-030 inv_done arriving outside WAIT SHALL be ignored.
REQ-031 At most one job SHALL be outstanding at the inverter at any time.

Reset
REQ-032 rst_n low SHALL immediately force the following, regardless of state, including mid-job:
  - state = IDLE;
  - rr_ptr, counter, inv_sel and inv_rank = 0;
  - ack, resp_success, resp_timeout, inv_start, inv_abort and busy = 0.
REQ-033 The first grant after rst_n deasserts SHALL occur no earlier than the first rising clk edge with rst_n high.

Verification
REQ-034 req=4'b0001, rank 5; inverter returns done+success after 10 cycles -> inv_start 1 cycle after grant, ack=4'b0001 with resp_success=1, busy falls the cycle after ack.
REQ-035 req=4'b1111 held, every job succeeds -> acks in order 0,1,2,3,0, each ack separated by one full job.
REQ-036 TIMEOUT_CYC=16, inverter never answers -> inv_abort pulses exactly once, 16 cycles after inv_start; ack with resp_timeout=1 and resp_success=0.
REQ-037 Rank 0, then rank RANK_MAX+1 -> no inv_start for either; acks with success 1 then 0, 2 cycles after each grant.
REQ-038 rst_n pulsed low during WAIT -> all outputs 0 asynchronously; a pending req is granted from rr_ptr=0 after release; a stale inv_done is ignored.
REQ-039 inv_done on the same cycle the counter reaches TIMEOUT_CYC-1 -> no inv_abort, resp_timeout=0, success taken from inv_success.

Source files
------------

// File: rtl/inv_scheduler.sv
// inv_scheduler: round-robin arbiter that lends one GF(2) matrix inverter to
// NUM_REQ requesters, one job at a time, with a watchdog that aborts jobs the
// inverter never finishes. Trivial ranks (0 or above RANK_MAX) are answered
// locally without touching the inverter.
module inv_scheduler #(
  parameter  int NUM_REQ     = 4,
  parameter  int RANK_MAX    = 936,
  parameter  int TIMEOUT_CYC = 4096,
  localparam int RANK_W      = $clog2(RANK_MAX),
  localparam int SEL_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W       = $clog2(TIMEOUT_CYC) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*RANK_W-1:0] req_rank,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      resp_success,
  output logic                      resp_timeout,
  output logic                      inv_start,
  output logic [RANK_W-1:0]         inv_rank,
  output logic [SEL_W-1:0]          inv_sel,
  output logic                      inv_abort,
  input  logic                      inv_done,
  input  logic                      inv_success,
  output logic                      busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   sel, rr_ptr;
  logic [RANK_W-1:0]  rank;
  logic [CNT_W-1:0]   cnt;
  logic               res_succ, res_to;

  logic               gnt_vld;
  logic [SEL_W-1:0]   gnt_idx, cand;
  logic               rank_zero, rank_bad, to_hit;

  // Rank compared one bit wider so RANK_MAX itself always fits.
  assign rank_zero = (rank == '0);
  assign rank_bad  = ({1'b0, rank} > (RANK_W+1)'(RANK_MAX));
  assign to_hit    = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Round-robin pick: scan offsets high to low so the smallest offset from
  // rr_ptr is the last (winning) assignment.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = SEL_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; inv_done beats the watchdog when both land together.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (gnt_vld) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (rank_zero || rank_bad) ? S_RESP : S_WAIT;
      S_WAIT:  if (inv_done || to_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job datapath: grant latch, watchdog counter, result flags, rr pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel      <= '0;
      rank     <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      res_succ <= 1'b0;
      res_to   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (gnt_vld) begin
          sel  <= gnt_idx;
          rank <= req_rank[gnt_idx*RANK_W +: RANK_W];
        end
        S_ISSUE: begin
          cnt      <= '0;
          res_succ <= rank_zero;   // rank 0 is trivially invertible
          res_to   <= 1'b0;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (inv_done) begin
            res_succ <= inv_success;
            res_to   <= 1'b0;
          end else if (to_hit) begin
            res_succ <= 1'b0;
            res_to   <= 1'b1;
          end
        end
        S_RESP: rr_ptr <= (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state so reset clears them at once.
  always_comb begin
    inv_start    = (state == S_ISSUE) && !rank_zero && !rank_bad;
    inv_abort    = (state == S_WAIT) && to_hit && !inv_done;
    ack          = (state == S_RESP) ? (NUM_REQ'(1) << sel) : '0;
    resp_success = (state == S_RESP) && res_succ;
    resp_timeout = (state == S_RESP) && res_to;
    busy         = (state != S_IDLE);
    inv_sel      = sel;
    inv_rank     = rank;
  end

endmodule
